// File: rtl/axi4_burst_master.sv
// AXI4 INCR burst master: independent write and read engines driven by an AMCI command/stream port.
// Optional macro AXI_4K_CHECK_EN rejects bursts that would cross a 4 KB boundary.
module axi4_burst_master #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BEATS      = 16,
  parameter int AXI_ID         = 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  // AMCI write side
  input  logic [AXI_ADDR_WIDTH-1:0]   AMCI_WADDR,
  input  logic [7:0]                  AMCI_WLEN,
  input  logic                        AMCI_WRITE,
  input  logic [AXI_DATA_WIDTH-1:0]   AMCI_WDATA,
  input  logic                        AMCI_WDATA_VALID,
  output logic                        AMCI_WDATA_READY,
  output logic [1:0]                  AMCI_WRESP,
  output logic                        AMCI_WIDLE,
  // AMCI read side
  input  logic [AXI_ADDR_WIDTH-1:0]   AMCI_RADDR,
  input  logic [7:0]                  AMCI_RLEN,
  input  logic                        AMCI_READ,
  output logic [AXI_DATA_WIDTH-1:0]   AMCI_RDATA,
  output logic                        AMCI_RDATA_VALID,
  input  logic                        AMCI_RDATA_READY,
  output logic [1:0]                  AMCI_RRESP,
  output logic                        AMCI_RIDLE,
  // AXI AW
  output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  output logic                        AWVALID,
  input  logic                        AWREADY,
  output logic [7:0]                  AWLEN,
  output logic [2:0]                  AWSIZE,
  output logic [1:0]                  AWBURST,
  output logic [3:0]                  AWID,
  output logic                        AWLOCK,
  output logic [3:0]                  AWCACHE,
  output logic [3:0]                  AWQOS,
  output logic [2:0]                  AWPROT,
  // AXI W
  output logic [AXI_DATA_WIDTH-1:0]   WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
  output logic                        WVALID,
  input  logic                        WREADY,
  output logic                        WLAST,
  // AXI B
  input  logic [1:0]                  BRESP,
  input  logic                        BVALID,
  output logic                        BREADY,
  // AXI AR
  output logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
  output logic                        ARVALID,
  input  logic                        ARREADY,
  output logic [7:0]                  ARLEN,
  output logic [2:0]                  ARSIZE,
  output logic [1:0]                  ARBURST,
  output logic [3:0]                  ARID,
  output logic                        ARLOCK,
  output logic [3:0]                  ARCACHE,
  output logic [3:0]                  ARQOS,
  output logic [2:0]                  ARPROT,
  // AXI R
  input  logic [AXI_DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]                  RRESP,
  input  logic                        RVALID,
  input  logic                        RLAST,
  output logic                        RREADY
);

  localparam int         BYTES   = AXI_DATA_WIDTH / 8;
  localparam logic [2:0] SIZE    = 3'($clog2(BYTES));
  localparam logic [7:0] MAX_LEN = 8'(MAX_BEATS - 1);

  function automatic logic [7:0] clamp_len(input logic [7:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_XFER} rstate_t;

  wstate_t wstate_reg, wstate_next;
  rstate_t rstate_reg, rstate_next;

  logic [AXI_ADDR_WIDTH-1:0] awaddr_reg, araddr_reg;
  logic [7:0]                awlen_reg, arlen_reg, beat_reg;
  logic                      awvalid_reg, arvalid_reg, wdone_reg;
  logic [1:0]                wresp_reg, rresp_reg, racc_reg;

  logic w_reject, r_reject;
  logic w_cmd, r_cmd, w_start, r_start;
  logic w_active, w_hs, w_last, aw_hs, aw_done_now, w_done_now;
  logic r_active, r_hs, ar_hs;
  logic [1:0] rresp_max;

`ifdef AXI_4K_CHECK_EN
  // Byte offset just past the burst, relative to its 4 KB page.
  function automatic logic crosses_4k(input logic [AXI_ADDR_WIDTH-1:0] addr, input logic [7:0] len);
    logic [31:0] end_off;
    end_off = 32'(addr[11:0]) + (32'(len) + 32'd1) * 32'(BYTES);
    return end_off > 32'd4096;
  endfunction
  assign w_reject = crosses_4k(AMCI_WADDR, clamp_len(AMCI_WLEN));
  assign r_reject = crosses_4k(AMCI_RADDR, clamp_len(AMCI_RLEN));
`else
  assign w_reject = 1'b0;
  assign r_reject = 1'b0;
`endif

  // Constant AXI attributes
  assign AWSIZE  = SIZE;
  assign AWBURST = 2'b01;
  assign AWID    = 4'(AXI_ID);
  assign AWLOCK  = 1'b0;
  assign AWCACHE = 4'd2;
  assign AWQOS   = 4'd0;
  assign AWPROT  = 3'd0;
  assign ARSIZE  = SIZE;
  assign ARBURST = 2'b01;
  assign ARID    = 4'(AXI_ID);
  assign ARLOCK  = 1'b0;
  assign ARCACHE = 4'd2;
  assign ARQOS   = 4'd0;
  assign ARPROT  = 3'd0;
  assign WSTRB   = '1;
  assign WDATA   = AMCI_WDATA;

  assign AWADDR     = awaddr_reg;
  assign AWLEN      = awlen_reg;
  assign AWVALID    = awvalid_reg;
  assign ARADDR     = araddr_reg;
  assign ARLEN      = arlen_reg;
  assign ARVALID    = arvalid_reg;
  assign AMCI_WRESP = wresp_reg;
  assign AMCI_RRESP = rresp_reg;

  // ---------------- write engine ----------------
  assign w_cmd       = (wstate_reg == W_IDLE) && AMCI_WRITE;
  assign w_start     = w_cmd && !w_reject;
  assign w_active    = (wstate_reg == W_XFER) && !wdone_reg;
  assign w_hs        = w_active && AMCI_WDATA_VALID && WREADY;
  assign w_last      = (beat_reg == awlen_reg);
  assign aw_hs       = awvalid_reg && AWREADY;
  assign aw_done_now = !awvalid_reg || AWREADY;
  assign w_done_now  = wdone_reg || (w_hs && w_last);

  always_ff @(posedge clk) begin
    if (!resetn) wstate_reg <= W_IDLE;
    else         wstate_reg <= wstate_next;
  end

  always_comb begin
    wstate_next = wstate_reg;
    case (wstate_reg)
      W_IDLE:  if (w_start) wstate_next = W_XFER;
      W_XFER:  if (aw_done_now && w_done_now) wstate_next = W_RESP;
      W_RESP:  if (BVALID) wstate_next = W_IDLE;
      default: wstate_next = W_IDLE;
    endcase
  end

  always_comb begin
    WVALID           = w_active && AMCI_WDATA_VALID;
    AMCI_WDATA_READY = w_active && WREADY;
    WLAST            = WVALID && w_last;
    BREADY           = (wstate_reg == W_RESP);
    AMCI_WIDLE       = (wstate_reg == W_IDLE) && !AMCI_WRITE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      awaddr_reg  <= '0;
      awlen_reg   <= '0;
      awvalid_reg <= 1'b0;
      beat_reg    <= '0;
      wdone_reg   <= 1'b0;
      wresp_reg   <= 2'b00;
    end else begin
      if (w_start) begin
        awaddr_reg  <= AMCI_WADDR;
        awlen_reg   <= clamp_len(AMCI_WLEN);
        awvalid_reg <= 1'b1;
        beat_reg    <= '0;
        wdone_reg   <= 1'b0;
      end else if (w_cmd && w_reject) begin
        wresp_reg <= 2'b10;
      end
      if (aw_hs) awvalid_reg <= 1'b0;
      if (w_hs) begin
        beat_reg <= beat_reg + 8'd1;
        if (w_last) wdone_reg <= 1'b1;
      end
      if ((wstate_reg == W_RESP) && BVALID) wresp_reg <= BRESP;
    end
  end

  // ---------------- read engine ----------------
  assign r_cmd     = (rstate_reg == R_IDLE) && AMCI_READ;
  assign r_start   = r_cmd && !r_reject;
  assign r_active  = (rstate_reg == R_XFER);
  assign r_hs      = r_active && RVALID && AMCI_RDATA_READY;
  assign ar_hs     = arvalid_reg && ARREADY;
  assign rresp_max = (RRESP > racc_reg) ? RRESP : racc_reg;

  always_ff @(posedge clk) begin
    if (!resetn) rstate_reg <= R_IDLE;
    else         rstate_reg <= rstate_next;
  end

  always_comb begin
    rstate_next = rstate_reg;
    case (rstate_reg)
      R_IDLE:  if (r_start) rstate_next = R_XFER;
      R_XFER:  if (r_hs && RLAST) rstate_next = R_IDLE;
      default: rstate_next = R_IDLE;
    endcase
  end

  always_comb begin
    RREADY           = r_active && AMCI_RDATA_READY;
    AMCI_RDATA_VALID = r_active && RVALID;
    AMCI_RDATA       = r_active ? RDATA : '0;
    AMCI_RIDLE       = (rstate_reg == R_IDLE) && !AMCI_READ;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      araddr_reg  <= '0;
      arlen_reg   <= '0;
      arvalid_reg <= 1'b0;
      racc_reg    <= 2'b00;
      rresp_reg   <= 2'b00;
    end else begin
      if (r_start) begin
        araddr_reg  <= AMCI_RADDR;
        arlen_reg   <= clamp_len(AMCI_RLEN);
        arvalid_reg <= 1'b1;
        racc_reg    <= 2'b00;
      end else if (r_cmd && r_reject) begin
        rresp_reg <= 2'b10;
      end
      if (ar_hs) arvalid_reg <= 1'b0;
      // RLAST alone ends the burst; the beat count is not checked.
      if (r_hs) begin
        racc_reg <= rresp_max;
        if (RLAST) rresp_reg <= rresp_max;
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: table rows plus random rows against a queue-based slave/stream model.
module tb_axi4_burst_master;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [AW-1:0] AMCI_WADDR, AMCI_RADDR, AWADDR, ARADDR;
  logic [7:0]    AMCI_WLEN, AMCI_RLEN, AWLEN, ARLEN;
  logic          AMCI_WRITE, AMCI_READ, AMCI_WDATA_VALID, AMCI_WDATA_READY, AMCI_WIDLE;
  logic          AMCI_RDATA_VALID, AMCI_RDATA_READY, AMCI_RIDLE;
  logic [DW-1:0] AMCI_WDATA, AMCI_RDATA, WDATA, RDATA;
  logic [1:0]    AMCI_WRESP, AMCI_RRESP, AWBURST, ARBURST, BRESP, RRESP;
  logic          AWVALID, AWREADY, AWLOCK, ARVALID, ARREADY, ARLOCK;
  logic [2:0]    AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [3:0]    AWID, ARID, AWCACHE, ARCACHE, AWQOS, ARQOS;
  logic [DW/8-1:0] WSTRB;
  logic          WVALID, WREADY, WLAST, BVALID, BREADY, RVALID, RLAST, RREADY;

  axi4_burst_master #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .MAX_BEATS(MAXB), .AXI_ID(1)) dut (
    .clk(clk), .resetn(resetn),
    .AMCI_WADDR(AMCI_WADDR), .AMCI_WLEN(AMCI_WLEN), .AMCI_WRITE(AMCI_WRITE),
    .AMCI_WDATA(AMCI_WDATA), .AMCI_WDATA_VALID(AMCI_WDATA_VALID), .AMCI_WDATA_READY(AMCI_WDATA_READY),
    .AMCI_WRESP(AMCI_WRESP), .AMCI_WIDLE(AMCI_WIDLE),
    .AMCI_RADDR(AMCI_RADDR), .AMCI_RLEN(AMCI_RLEN), .AMCI_READ(AMCI_READ),
    .AMCI_RDATA(AMCI_RDATA), .AMCI_RDATA_VALID(AMCI_RDATA_VALID), .AMCI_RDATA_READY(AMCI_RDATA_READY),
    .AMCI_RRESP(AMCI_RRESP), .AMCI_RIDLE(AMCI_RIDLE),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWID(AWID), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWQOS(AWQOS), .AWPROT(AWPROT),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARID(ARID), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARQOS(ARQOS), .ARPROT(ARPROT),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
  );

  // One row: command stimulus, slave/stream behaviour modes, expected results.
  // Modes: 0 = always ready/valid, 1 = every other cycle, 2 = random (aw_mode 2 = withhold until all W beats sent).
  typedef struct {
    bit          do_wr, do_rd, repulse, rand_resp;
    logic [31:0] waddr, wdata0, raddr;
    logic [7:0]  wlen, rlen, exp_awlen, exp_arlen;
    logic [1:0]  bresp, bad_resp, exp_wresp;
    int          bad_beat, exp_rresp, exp_wlat;
    int          aw_mode, w_mode, src_mode, sink_mode, r_mode;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  vec_t        cur;
  vec_t        tab[6];
  bit          wr_pulse, rd_pulse;
  logic [31:0] src_q[$];
  logic [31:0] rq[$];
  logic [1:0]  rrq[$];
  int          w_seen, aw_cnt, ar_cnt, r_got, werr, rerr, aw_err, idle_err;
  int          aw_rise, ar_rise, wlat, wpulse_cyc, rpulse_cyc, rlast_cyc;
  bit          b_pend, b_issued, b_done, r_done, r_busy, ridle_ok;
  logic [7:0]  got_awlen, got_arlen;
  logic [1:0]  rmax;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Spec rule: issued length is min(requested, MAX_BEATS-1).
  function automatic logic [7:0] model_len(input logic [7:0] l);
    return (int'(l) > MAXB - 1) ? 8'(MAXB - 1) : l;
  endfunction

  function automatic logic [31:0] rand_addr(input logic [7:0] elen);
    logic [31:0] a;
    a = $urandom & 32'hFFFF_F000;
    return a | (32'($urandom_range(0, 1023 - int'(elen))) << 2);
  endfunction

  function automatic vec_t blank();
    vec_t v;
    v = '{default: 0};
    v.bad_beat  = -1;
    v.exp_rresp = -1;
    v.exp_wlat  = -1;
    return v;
  endfunction

  function automatic bit pick(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return 1'($urandom % 2);
  endfunction

  task automatic clear_row_state();
    w_seen = 0; aw_cnt = 0; ar_cnt = 0; r_got = 0; werr = 0; rerr = 0; aw_err = 0; idle_err = 0;
    aw_rise = -1; ar_rise = -1; wlat = -1; rlast_cyc = -10;
    b_pend = 0; b_issued = 0; b_done = 0; r_done = 0; r_busy = 0; ridle_ok = 0;
    got_awlen = 'x; got_arlen = 'x; rmax = 2'b00;
    rq.delete(); rrq.delete();
  endtask

  // Drive at negedge, let combinational outputs settle, then record the handshakes of the coming posedge.
  task automatic tick();
    logic [1:0] resp;
    @(negedge clk);
    AMCI_WRITE       = wr_pulse;
    AMCI_READ        = rd_pulse;
    AWREADY          = (cur.aw_mode == 2) ? (w_seen == int'(cur.exp_awlen) + 1) : pick(cur.aw_mode);
    WREADY           = pick(cur.w_mode);
    BVALID           = b_pend;
    BRESP            = cur.bresp;
    ARREADY          = pick(cur.r_mode == 0 ? 0 : 2);
    RVALID           = (rq.size() > 0) && pick(cur.r_mode == 0 ? 0 : 2);
    RDATA            = (rq.size() > 0) ? rq[0] : 32'h0;
    RRESP            = (rrq.size() > 0) ? rrq[0] : 2'b00;
    RLAST            = (rq.size() == 1);
    AMCI_WDATA_VALID = (src_q.size() > 0) && pick(cur.src_mode);
    AMCI_WDATA       = (src_q.size() > 0) ? src_q[0] : 32'h0;
    AMCI_RDATA_READY = pick(cur.sink_mode);
    #1;
    if (wr_pulse && AMCI_WIDLE !== 1'b0) idle_err++;
    if (rd_pulse && AMCI_RIDLE !== 1'b0) idle_err++;
    if (cur.do_wr && wlat < 0 && cyc > wpulse_cyc && AMCI_WIDLE === 1'b1) wlat = cyc - wpulse_cyc;
    if (r_done && cyc == rlast_cyc + 1) ridle_ok = (AMCI_RIDLE === 1'b1);
    if (r_busy && AMCI_RIDLE !== 1'b0) idle_err++;
    // write side
    if (AWVALID === 1'b1) begin
      if (aw_rise < 0) aw_rise = cyc - wpulse_cyc;
      if (AWADDR !== cur.waddr) aw_err++;
    end
    if (AWVALID && AWREADY) begin aw_cnt++; got_awlen = AWLEN; end
    if ((WVALID && WREADY) !== (AMCI_WDATA_VALID && AMCI_WDATA_READY)) werr++;
    if (WLAST === 1'b1 && WVALID !== 1'b1) werr++;
    if (WVALID && WREADY) begin
      if (src_q.size() == 0 || WDATA !== src_q[0]) werr++;
      if (WLAST !== (w_seen == int'(cur.exp_awlen))) werr++;
      if (src_q.size() > 0) void'(src_q.pop_front());
      w_seen++;
    end
    if (BVALID && BREADY) begin b_pend = 0; b_done = 1; end
    if (!b_issued && aw_cnt > 0 && w_seen == int'(cur.exp_awlen) + 1) begin b_pend = 1; b_issued = 1; end
    // read side
    if (RREADY !== (r_busy && AMCI_RDATA_READY)) rerr++;
    if (AMCI_RDATA_VALID !== (r_busy && RVALID)) rerr++;
    if (ARVALID === 1'b1) begin
      if (ar_rise < 0) ar_rise = cyc - rpulse_cyc;
      if (ARADDR !== cur.raddr) aw_err++;
    end
    if (ARVALID && ARREADY) begin
      ar_cnt++;
      got_arlen = ARLEN;
      for (int i = 0; i <= int'(ARLEN); i++) begin
        resp = (i == cur.bad_beat) ? cur.bad_resp :
               (cur.rand_resp && $urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        rq.push_back($urandom);
        rrq.push_back(resp);
        if (resp > rmax) rmax = resp;
      end
    end
    if (RVALID && RREADY) begin
      if (AMCI_RDATA_VALID !== 1'b1 || AMCI_RDATA !== rq[0]) rerr++;
      void'(rq.pop_front());
      void'(rrq.pop_front());
      r_got++;
      if (RLAST) begin r_done = 1; rlast_cyc = cyc; r_busy = 0; end
    end
    if (rd_pulse) r_busy = 1;
    wr_pulse = 0;
    rd_pulse = 0;
    cyc++;
  endtask

  task automatic run_row(input int idx);
    int n;
    clear_row_state();
    if (cur.do_wr)
      for (int i = 0; i <= int'(cur.exp_awlen); i++) src_q.push_back(cur.wdata0 + 32'(i) * 32'h0101_0101);
    AMCI_WADDR = cur.waddr; AMCI_WLEN = cur.wlen;
    AMCI_RADDR = cur.raddr; AMCI_RLEN = cur.rlen;
    wr_pulse = cur.do_wr; rd_pulse = cur.do_rd;
    wpulse_cyc = cyc; rpulse_cyc = cyc;
    tick();
    n = 0;
    while (!((!cur.do_wr || b_done) && (!cur.do_rd || r_done)) && n < 3000) begin
      if (cur.repulse && n == 1) begin
        wr_pulse = 1;
        AMCI_WADDR = 32'h0000_8000;
      end
      tick();
      n++;
    end
    chk($sformatf("row%0d_done", idx), n < 3000, 1);
    tick();
    chk($sformatf("row%0d_idle_flags", idx), idle_err, 0);
    chk($sformatf("row%0d_addr_stable", idx), aw_err, 0);
    if (cur.do_wr) begin
      chk($sformatf("row%0d_aw_count", idx), aw_cnt, 1);
      chk($sformatf("row%0d_awlen", idx), got_awlen, cur.exp_awlen);
      chk($sformatf("row%0d_awvalid_rise", idx), aw_rise, 1);
      chk($sformatf("row%0d_w_beats", idx), w_seen, int'(cur.exp_awlen) + 1);
      chk($sformatf("row%0d_w_stream", idx), werr, 0);
      chk($sformatf("row%0d_wresp", idx), AMCI_WRESP, cur.exp_wresp);
      chk($sformatf("row%0d_widle", idx), AMCI_WIDLE, 1);
      if (cur.exp_wlat >= 0) chk($sformatf("row%0d_wlat", idx), wlat, cur.exp_wlat);
    end else begin
      chk($sformatf("row%0d_no_aw", idx), aw_cnt, 0);
    end
    if (cur.do_rd) begin
      chk($sformatf("row%0d_ar_count", idx), ar_cnt, 1);
      chk($sformatf("row%0d_arlen", idx), got_arlen, cur.exp_arlen);
      chk($sformatf("row%0d_arvalid_rise", idx), ar_rise, 1);
      chk($sformatf("row%0d_r_beats", idx), r_got, int'(cur.exp_arlen) + 1);
      chk($sformatf("row%0d_r_stream", idx), rerr, 0);
      chk($sformatf("row%0d_ridle_after_last", idx), ridle_ok, 1);
      chk($sformatf("row%0d_rresp", idx), AMCI_RRESP, (cur.exp_rresp >= 0) ? 2'(cur.exp_rresp) : rmax);
    end else begin
      chk($sformatf("row%0d_no_ar", idx), ar_cnt, 0);
    end
    $display("txn %0d: wr=%0b addr=%h len=%0d wresp=%0d | rd=%0b addr=%h len=%0d rresp=%0d | end cycle %0d",
             idx, cur.do_wr, cur.waddr, cur.wlen, AMCI_WRESP, cur.do_rd, cur.raddr, cur.rlen, AMCI_RRESP, cyc);
  endtask

  initial begin
    cur = blank();
    clear_row_state();
    wr_pulse = 0; rd_pulse = 0;
    AMCI_WADDR = '0; AMCI_WLEN = '0; AMCI_RADDR = '0; AMCI_RLEN = '0;
    AMCI_WRITE = 0; AMCI_READ = 0; BRESP = 0; RRESP = 0; RDATA = '0; RLAST = 0; AMCI_WDATA = '0;
    // Reset with every upstream valid/ready high so that the IDLE gating is what holds outputs low.
    resetn = 0;
    AMCI_WDATA_VALID = 1; WREADY = 1; RVALID = 1; AMCI_RDATA_READY = 1;
    AWREADY = 1; ARREADY = 1; BVALID = 1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_wlast", WLAST, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_wdata_ready", AMCI_WDATA_READY, 0);
    chk("rst_rdata_valid", AMCI_RDATA_VALID, 0);
    chk("rst_widle", AMCI_WIDLE, 1);
    chk("rst_ridle", AMCI_RIDLE, 1);
    chk("rst_wresp", AMCI_WRESP, 0);
    chk("rst_rresp", AMCI_RRESP, 0);
    chk("const_awsize", AWSIZE, 2);
    chk("const_awburst", AWBURST, 1);
    chk("const_arcache", ARCACHE, 2);
    chk("const_wstrb", WSTRB, 4'hF);
    chk("const_awid", AWID, 1);
    resetn = 1;
    repeat (2) tick();

    // Directed rows.
    tab[0] = blank(); tab[0].do_wr = 1; tab[0].waddr = 32'h100; tab[0].wlen = 0; tab[0].wdata0 = 32'hDEADBEEF;
    tab[0].exp_awlen = 0; tab[0].exp_wresp = 0; tab[0].exp_wlat = 3;
    tab[1] = blank(); tab[1].do_wr = 1; tab[1].waddr = 32'h2000; tab[1].wlen = 15; tab[1].wdata0 = 32'h1000_0000;
    tab[1].bresp = 2'b01; tab[1].w_mode = 1; tab[1].aw_mode = 2; tab[1].repulse = 1;
    tab[1].exp_awlen = 15; tab[1].exp_wresp = 2'b01;
    tab[2] = blank(); tab[2].do_rd = 1; tab[2].raddr = 32'h400; tab[2].rlen = 7; tab[2].sink_mode = 1;
    tab[2].exp_arlen = 7; tab[2].exp_rresp = 0;
    tab[3] = blank(); tab[3].do_rd = 1; tab[3].raddr = 32'h800; tab[3].rlen = 3; tab[3].bad_beat = 1;
    tab[3].bad_resp = 2'b10; tab[3].exp_arlen = 3; tab[3].exp_rresp = 2;
    tab[4] = blank(); tab[4].do_wr = 1; tab[4].do_rd = 1; tab[4].waddr = 32'h3040; tab[4].wlen = 255;
    tab[4].wdata0 = 32'hA5A5_0000; tab[4].raddr = 32'h5000; tab[4].rlen = 5; tab[4].src_mode = 2;
    tab[4].sink_mode = 2; tab[4].r_mode = 2; tab[4].exp_awlen = 15; tab[4].exp_arlen = 5; tab[4].exp_rresp = 0;
    tab[5] = blank(); tab[5].do_wr = 1; tab[5].do_rd = 1; tab[5].waddr = 32'h6100; tab[5].wlen = 2;
    tab[5].bresp = 2'b10; tab[5].aw_mode = 2; tab[5].w_mode = 2; tab[5].raddr = 32'h7000; tab[5].rlen = 255;
    tab[5].bad_beat = 3; tab[5].bad_resp = 2'b11; tab[5].exp_awlen = 2; tab[5].exp_wresp = 2'b10;
    tab[5].exp_arlen = 15; tab[5].exp_rresp = 3;
    for (int i = 0; i < 6; i++) begin
      cur = tab[i];
      run_row(i);
    end

    // Random rows, expectations from the model.
    for (int k = 0; k < 24; k++) begin
      cur = blank();
      cur.do_wr = 1'($urandom % 2);
      cur.do_rd = 1'($urandom % 2);
      if (!cur.do_wr && !cur.do_rd) cur.do_wr = 1;
      cur.wlen = 8'($urandom_range(0, 40));
      cur.exp_awlen = model_len(cur.wlen);
      cur.waddr = rand_addr(cur.exp_awlen);
      cur.wdata0 = $urandom;
      cur.bresp = 2'($urandom);
      cur.exp_wresp = cur.bresp;
      cur.rlen = 8'($urandom_range(0, 40));
      cur.exp_arlen = model_len(cur.rlen);
      cur.raddr = rand_addr(cur.exp_arlen);
      cur.rand_resp = 1;
      cur.aw_mode = $urandom_range(0, 2); cur.w_mode = $urandom_range(0, 2);
      cur.src_mode = $urandom_range(0, 2); cur.sink_mode = $urandom_range(0, 2);
      cur.r_mode = $urandom_range(0, 2);
      run_row(6 + k);
    end

`ifdef AXI_4K_CHECK_EN
    // 0xFF8 + 4*4 bytes crosses the page: rejected with no AXI activity.
    cur = blank(); cur.do_wr = 1; cur.waddr = 32'hFF8; cur.wlen = 3; cur.exp_awlen = 3;
    clear_row_state();
    for (int i = 0; i < 4; i++) src_q.push_back(32'hC0DE_0000 + 32'(i));
    AMCI_WADDR = cur.waddr; AMCI_WLEN = cur.wlen;
    wr_pulse = 1; wpulse_cyc = cyc;
    tick();
    repeat (6) tick();
    chk("rej4k_no_awvalid", aw_rise, -1);
    chk("rej4k_wresp", AMCI_WRESP, 2'b10);
    chk("rej4k_widle_next", wlat, 1);
    chk("rej4k_no_consume", src_q.size(), 4);
    src_q.delete();
    cur = blank(); cur.do_wr = 1; cur.waddr = 32'hFF0; cur.wlen = 3; cur.wdata0 = 32'h0BAD_F00D;
    cur.exp_awlen = 3; cur.exp_wresp = 0;
    run_row(100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_burst_master.md
# axi4_burst_master

Parametrised AXI4 master that performs full-width INCR bursts of 1..MAX_BEATS beats on behalf of a local AMCI-style command interface. Write data is streamed in and read data streamed out over valid/ready handshakes, so a DMA engine or register sequencer can move blocks without per-word address phases. Write and read channels run independently and may be active at the same time. It sits between user logic and an AXI interconnect slave port.

## Interface
Parameters:
- AXI_DATA_WIDTH, 32: data bus width in bits; power of two, at least 32.
- AXI_ADDR_WIDTH, 32: address width in bits.
- MAX_BEATS, 16: largest burst in beats; range 1..256.
- AXI_ID, 1: constant value driven on AWID and ARID.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- AMCI_WADDR  in  ADDR  write burst start address; must be data-width aligned.
- AMCI_WLEN  in  8  write burst beats minus 1.
- AMCI_WRITE  in  1  single-cycle start pulse for a write burst.
- AMCI_WDATA  in  DATA  write data stream, data.
- AMCI_WDATA_VALID  in  1  write data stream, valid.
- AMCI_WDATA_READY  out  1  write data stream, ready.
- AMCI_WRESP  out  2  final write response.
- AMCI_WIDLE  out  1  write engine idle.
- AMCI_RADDR  in  ADDR  read burst start address; must be aligned.
- AMCI_RLEN  in  8  read burst beats minus 1.
- AMCI_READ  in  1  single-cycle start pulse for a read burst.
- AMCI_RDATA  out  DATA  read data stream, data.
- AMCI_RDATA_VALID  out  1  read data stream, valid.
- AMCI_RDATA_READY  in  1  read data stream, ready.
- AMCI_RRESP  out  2  worst read response of the burst.
- AMCI_RIDLE  out  1  read engine idle.
- AXI AW channel  out  standard AXI4 widths  AWADDR, AWVALID, AWLEN, AWSIZE, AWBURST, AWID, AWLOCK, AWCACHE, AWQOS, AWPROT; AWREADY is an input.
- AXI W channel  out  standard AXI4 widths  WDATA, WSTRB, WVALID, WLAST; WREADY is an input.
- AXI B channel  BRESP and BVALID in; BREADY out.
- AXI AR channel  out  standard AXI4 widths  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, ARID, ARLOCK, ARCACHE, ARQOS, ARPROT; ARREADY is an input.
- AXI R channel  RDATA, RRESP, RVALID and RLAST in; RREADY out.

## Operation
Constant AXI outputs:
- AxBURST=1 (INCR), AxSIZE=log2(DATA/8), AxCACHE=2, AxLOCK=0, AxQOS=0, AxPROT=0, AxID=AXI_ID, WSTRB=all ones.

Command handling:
- An effective length is computed as min(AxLEN_cmd, MAX_BEATS-1) and latched into AWLEN/ARLEN.
- AMCI_WRITE or AMCI_READ is ignored unless its own engine is in IDLE.

Write FSM:
- W_IDLE: on AMCI_WRITE, latch AWADDR and AWLEN, clear the beat counter, set AWVALID=1, go to W_XFER.
- W_XFER: AWVALID drops on the AW handshake.
  - WVALID=AMCI_WDATA_VALID and AMCI_WDATA_READY=WREADY; both are gated to 0 outside W_XFER and after the last beat.
  - WDATA is a combinational pass-through of AMCI_WDATA.
  - WLAST=(beat counter==AWLEN). The counter increments on each W handshake.
  - AW and W may complete in any order, including the same cycle. Leave W_XFER when both the AW handshake and the last W handshake are done.
- W_RESP: BREADY=1. On the B handshake, AMCI_WRESP<=BRESP, BREADY<=0, go to W_IDLE.

Read FSM:
- R_IDLE: on AMCI_READ, latch ARADDR and ARLEN, set ARVALID=1, clear the response accumulator, go to R_XFER.
- R_XFER: ARVALID drops on the AR handshake.
  - AMCI_RDATA=RDATA, AMCI_RDATA_VALID=RVALID, RREADY=AMCI_RDATA_READY; all are gated to 0 outside R_XFER.
  - On each R handshake the accumulator <= max(accumulator, RRESP).
  - On the R handshake with RLAST=1: AMCI_RRESP<=max(accumulator, RRESP), go to R_IDLE.
  - RLAST is authoritative. No beat count is checked on read.

Idle outputs:
- AMCI_WIDLE=(state==W_IDLE)&&!AMCI_WRITE.
- AMCI_RIDLE=(state==R_IDLE)&&!AMCI_READ.

## Timing
- Reset: FSMs go to IDLE. AWVALID, BREADY and ARVALID are 0. AMCI_WRESP and AMCI_RRESP are 0.
- Reset outputs (combinational): WVALID, RREADY, AMCI_WDATA_READY and AMCI_RDATA_VALID are 0 as a result of the IDLE gating. WLAST is 0 while WVALID is 0. AMCI_WIDLE and AMCI_RIDLE are 1 unless AMCI_WRITE or AMCI_READ is high in that cycle.
- Reset mid-burst abandons the transaction with no cleanup. The bench must reset the slave alongside this block.
- AWVALID/ARVALID rise the cycle after the start pulse. They stay high with stable address until the handshake, as AXI requires.
- Minimum write latency, start pulse to AMCI_WIDLE=1, with an always-ready slave and source: 1 cycle, plus beats, plus 1 cycle for B.
- AMCI_RIDLE rises the cycle after the RLAST handshake.
- AMCI_WRESP and AMCI_RRESP are valid from the cycle their IDLE flag rises until the next command completes.

## Configuration
- Macro AXI_4K_CHECK_EN.
- Defined: a command whose address plus (len+1)×bytes crosses a 4 KB boundary is rejected.
  - No AXI activity is issued.
  - The engine returns 2'b10 (SLVERR) in AMCI_WRESP or AMCI_RRESP.
  - The engine stays in IDLE, and its IDLE flag is high the cycle after the pulse.
  - For a rejected write, no data is consumed from the AMCI write stream.
- Undefined: no check is made, and bursts are issued as commanded.

## Test plan
- 1-beat write to 0x100 with data 0xDEADBEEF, always-ready slave returning BRESP=0 -> AWLEN=0, WLAST on the first beat, AMCI_WRESP=0, AMCI_WIDLE high 3 cycles after the pulse.
- 16-beat write with WREADY toggling every cycle and AWREADY withheld until all data has been sent -> 16 W handshakes, WLAST only on beat 16, B accepted after the AW handshake, AMCI_WRESP=BRESP.
- 8-beat read with AMCI_RDATA_READY stalled every other cycle -> RREADY mirrors the stall, 8 words are delivered in order, AMCI_RRESP=0.
- 4-beat read where beat 2 returns RRESP=2 and the others return 0 -> AMCI_RRESP=2.
- Concurrent write and read at the same cycle, plus AMCI_WLEN=255 with MAX_BEATS=16 -> both complete independently, AWLEN=15.
- With AXI_4K_CHECK_EN: 4-beat write at 0xFF8 with 32-bit data -> no AWVALID, AMCI_WRESP=2.
- With AXI_4K_CHECK_EN: the same burst at 0xFF0 -> issued normally.
